grf_scoreboard: RTL and testbench

// - Hazard scheduler for the 32x32 general register file in the pipelined MIPS core.
// - Sits beside the D stage. Tracks in-flight writes per register with a remaining-latency counter (Tnew).
// - Checks the D-stage source operands against that state and produces the stall that freezes PC/F/D and bubbles E.
// - The GRF write port (RegWrite/RegAddr) is the retire point; $0 is never tracked.

---
 rtl/grf_scoreboard.sv | 108 ++++++++++
 tb/tb_grf_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// Register-file hazard scoreboard: per-register in-flight writer count and
// remaining latency, D-stage stall generation. Optional stall counter: GRF_SB_PERF_EN.
module grf_sb_entry #(
    parameter int TNEW_W = 3,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              retire_req,
    input  logic [TNEW_W-1:0] issue_tnew,
    output logic [CNT_W-1:0]  cnt,
    output logic [TNEW_W-1:0] tnew
);
    logic pending;
    logic retire;

    assign pending = (cnt != '0);
    // Retires against an untracked register are dropped so cnt never underflows.
    assign retire  = retire_req && pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tnew <= '0;
        end else begin
            if (accept && !retire)
                cnt <= cnt + CNT_W'(1);
            else if (!accept && retire)
                cnt <= cnt - CNT_W'(1);

            if (accept)
                tnew <= issue_tnew;
            else if (retire && cnt == CNT_W'(1))
                tnew <= '0;
            else if (pending && tnew != '0)
                tnew <= tnew - TNEW_W'(1);
        end
    end
endmodule

module grf_scoreboard #(
    parameter int TNEW_W = 3,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [4:0]        issue_rd,
    input  logic [TNEW_W-1:0] issue_tnew,
    input  logic              rs_read,
    input  logic              rt_read,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [1:0]        rs_tuse,
    input  logic [1:0]        rt_tuse,
    input  logic              RegWrite,
    input  logic [4:0]        RegAddr,
    output logic              stall,
    output logic              issue_accept,
    output logic              busy,
    output logic [31:0]       perf_stall_cnt
);
    logic [31:0][CNT_W-1:0]  cnt;
    logic [31:0][TNEW_W-1:0] tnew;
    logic [31:1]             pend;
    logic                    hz_rs, hz_rt, hz_sat;

    assign cnt[0]  = '0;
    assign tnew[0] = '0;

    for (genvar r = 1; r < 32; r++) begin : g_reg
        grf_sb_entry #(.TNEW_W(TNEW_W), .CNT_W(CNT_W)) u_entry (
            .clk        (clk),
            .reset      (reset),
            .accept     (issue_accept && issue_we && issue_rd == 5'(r)),
            .retire_req (RegWrite && RegAddr == 5'(r)),
            .issue_tnew (issue_tnew),
            .cnt        (cnt[r]),
            .tnew       (tnew[r])
        );
        assign pend[r] = (cnt[r] != '0);
    end

    // Same-cycle retire does not mask the hazard: only the value is bypassed.
    assign hz_rs  = rs_read && rs != 5'd0 && cnt[rs] != '0 && 32'(tnew[rs]) > 32'(rs_tuse);
    assign hz_rt  = rt_read && rt != 5'd0 && cnt[rt] != '0 && 32'(tnew[rt]) > 32'(rt_tuse);
    assign hz_sat = issue_we && issue_rd != 5'd0 && cnt[issue_rd] == {CNT_W{1'b1}};

    assign stall        = issue_valid && (hz_rs || hz_rt || hz_sat);
    assign issue_accept = issue_valid && !stall;
    assign busy         = |pend;

`ifdef GRF_SB_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset)
            perf_q <= '0;
        else if (stall && perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end
    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: directed literal scenarios plus
// random traffic compared against a ready-time based reference model.
module tb_grf_scoreboard;
    logic        clk = 0;
    logic        reset = 1;
    logic        issue_valid = 0, issue_we = 0;
    logic [4:0]  issue_rd = 0;
    logic [2:0]  issue_tnew = 0;
    logic        rs_read = 0, rt_read = 0;
    logic [4:0]  rs = 0, rt = 0;
    logic [1:0]  rs_tuse = 0, rt_tuse = 0;
    logic        RegWrite = 0;
    logic [4:0]  RegAddr = 0;
    logic        stall, issue_accept, busy;
    logic [31:0] perf_stall_cnt;

    grf_scoreboard dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_tnew(issue_tnew), .rs_read(rs_read), .rt_read(rt_read),
        .rs(rs), .rt(rt), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse), .RegWrite(RegWrite),
        .RegAddr(RegAddr), .stall(stall), .issue_accept(issue_accept), .busy(busy),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a register's latency is an absolute cycle number at which its
    // result becomes forwardable; remaining latency = max(0, ready - now).
    int          m_cnt[32];
    longint      m_ready[32];
    longint      cyc = 0;
    logic [31:0] m_perf = 0;
    bit          started = 0;

    function automatic int rem(input int r);
        return (m_ready[r] > cyc) ? int'(m_ready[r] - cyc) : 0;
    endfunction

    function automatic bit m_hz(input bit rd_en, input int r, input int tuse);
        return rd_en && r != 0 && m_cnt[r] > 0 && rem(r) > tuse;
    endfunction

    function automatic bit m_stall();
        bit sat;
        sat = issue_we && issue_rd != 0 && m_cnt[issue_rd] == 3;
        return issue_valid && (m_hz(rs_read, rs, rs_tuse) || m_hz(rt_read, rt, rt_tuse) || sat);
    endfunction

    function automatic bit m_busy();
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        bit st, acc_w, ret;
        st    = m_stall();
        acc_w = issue_valid && !st && issue_we && issue_rd != 0;
        ret   = RegWrite && RegAddr != 0 && m_cnt[RegAddr] > 0;
        cyc++;
        started = 1;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin m_cnt[r] = 0; m_ready[r] = 0; end
            m_perf = 0;
        end else begin
            if (st && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
`ifndef GRF_SB_PERF_EN
            m_perf = 0;
`endif
            if (acc_w && ret && issue_rd == RegAddr) begin
                m_ready[issue_rd] = cyc + issue_tnew;
            end else begin
                if (ret) begin
                    m_cnt[RegAddr]--;
                    if (m_cnt[RegAddr] == 0) m_ready[RegAddr] = 0;
                end
                if (acc_w) begin
                    m_cnt[issue_rd]++;
                    m_ready[issue_rd] = cyc + issue_tnew;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_stall", {31'd0, stall}, {31'd0, m_stall()});
            chk("m_accept", {31'd0, issue_accept}, {31'd0, issue_valid && !m_stall()});
            chk("m_busy", {31'd0, busy}, {31'd0, m_busy()});
            chk("m_perf", perf_stall_cnt, m_perf);
        end
    end

    task automatic go(input bit v, input bit we, input int rd, input int tn,
                      input bit rr, input int s, input int su,
                      input bit tr, input int t, input int tu,
                      input bit rw, input int ra);
        @(posedge clk); #1;
        issue_valid = v; issue_we = we; issue_rd = 5'(rd); issue_tnew = 3'(tn);
        rs_read = rr; rs = 5'(s); rs_tuse = 2'(su);
        rt_read = tr; rt = 5'(t); rt_tuse = 2'(tu);
        RegWrite = rw; RegAddr = 5'(ra);
        @(negedge clk);
    endtask

    task automatic idle();
        go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic iss(input int rd, input int tn);
        go(1, 1, rd, tn, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst();
        @(posedge clk); #1;
        reset = 1;
        issue_valid = 0; issue_we = 0; rs_read = 0; rt_read = 0; RegWrite = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
    endtask

    logic [31:0] exp_perf;

    initial begin
        rst();
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_perf", perf_stall_cnt, 0);

        // load-use
        iss(8, 2);
        chk("lu_accept_lw", {31'd0, issue_accept}, 1);
        go(1, 1, 10, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        chk("lu_stall", {31'd0, stall}, 1);
        go(1, 1, 10, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        chk("lu_release", {31'd0, stall}, 0);
        chk("lu_accept", {31'd0, issue_accept}, 1);
        // branch-use
        iss(9, 1);
        go(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
        chk("br_stall", {31'd0, stall}, 1);
        go(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
        chk("br_release", {31'd0, stall}, 0);

        // $0 never tracked
        rst();
        iss(0, 2);
        go(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_stall", {31'd0, stall}, 0);
        chk("r0_busy", {31'd0, busy}, 0);

        // two writers to one register
        rst();
        iss(5, 2);
        iss(5, 1);
        go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        chk("dw_busy_one_left", {31'd0, busy}, 1);
        idle();
        chk("dw_busy_clear", {31'd0, busy}, 0);

        // same-cycle accept+retire, spurious retire of $7
        rst();
        iss(6, 1);
        go(1, 1, 6, 2, 0, 0, 0, 0, 0, 0, 1, 6);
        go(1, 0, 0, 0, 1, 6, 1, 0, 0, 0, 1, 7);
        chk("ar_stall_tnew2", {31'd0, stall}, 1);
        go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        idle();
        chk("ar_busy_clear", {31'd0, busy}, 0);

        // writer-count saturation
        rst();
        iss(7, 0); iss(7, 0); iss(7, 0);
        chk("sat_third_accept", {31'd0, issue_accept}, 1);
        iss(7, 0);
        chk("sat_stall", {31'd0, stall}, 1);
        chk("sat_no_accept", {31'd0, issue_accept}, 0);

        // reset mid-flight, then stall counting
        rst();
        iss(1, 3); iss(2, 3); iss(3, 3);
        idle();
        chk("mf_busy", {31'd0, busy}, 1);
        rst();
        chk("mf_busy_reset", {31'd0, busy}, 0);
        go(1, 0, 0, 0, 1, 1, 0, 1, 2, 0, 0, 0);
        chk("mf_stall", {31'd0, stall}, 0);
        chk("mf_perf_zero", perf_stall_cnt, 0);
        iss(4, 3);
        for (int i = 0; i < 3; i++) begin
            go(1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
            chk("mf_stall_cnt_cycle", {31'd0, stall}, 1);
        end
        idle();
`ifdef GRF_SB_PERF_EN
        exp_perf = 3;
`else
        exp_perf = 0;
`endif
        chk("perf_count", perf_stall_cnt, exp_perf);

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset       = ($urandom_range(0, 149) == 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_we    = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 7));
            issue_tnew  = 3'($urandom_range(0, 4));
            rs_read     = $urandom_range(0, 1);
            rs          = 5'($urandom_range(0, 7));
            rs_tuse     = 2'($urandom_range(0, 3));
            rt_read     = $urandom_range(0, 1);
            rt          = 5'($urandom_range(0, 7));
            rt_tuse     = 2'($urandom_range(0, 3));
            RegWrite    = $urandom_range(0, 1);
            RegAddr     = 5'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
